// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and channel state encodings for the register slave.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register array with a byte-strobed write port, a combinational read mux and a flat
// view of all registers for fabric logic.
module axil_reg_bank #(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_we,
   input  logic [IDX_W-1:0]         i_widx,
   input  logic [31:0]              i_wdata,
   input  logic [3:0]               i_wstrb,
   input  logic [IDX_W-1:0]         i_ridx,
   output logic [31:0]              o_rdata,
   output logic [NUM_REGS*32-1:0]   o_regs
);

   logic [31:0] r_regs [NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      end else if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) r_regs[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   // read sees the pre-edge contents, so a same-edge write is invisible to it
   assign o_rdata = r_regs[i_ridx];

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign o_regs[k*32 +: 32] = r_regs[k];
   end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: write/read channel FSMs and address decode around axil_reg_bank.
// Define AXIL_SLV_DECERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  WR_IDLE | collecting AW and W (either order); commit when both present
//  WR_RESP | BVALID held with BRESP until BREADY
//  RD_IDLE | ARREADY high, waiting for a read address
//  RD_RESP | RVALID held with RDATA/RRESP until RREADY
module axi_lite_slave_regs
   import axil_pkg::*;
#(
   parameter  int ADDR_W   = 32,
   parameter  int NUM_REGS = 8,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
   input  logic [2:0]               S_AXI_AWPROT,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [31:0]              S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
   input  logic [2:0]               S_AXI_ARPROT,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]   regs_o,
   output logic                     wr_stb_o,
   output logic [IDX_W-1:0]         wr_idx_o
);

   localparam logic [ADDR_W-3:0] LP_NUM_REGS = (ADDR_W-2)'(NUM_REGS);
`ifdef AXIL_SLV_DECERR_EN
   localparam logic [1:0] LP_OOR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] LP_OOR_RESP = RESP_OKAY;
`endif

   wr_state_t r_wr_state, w_wr_state_nxt;
   rd_state_t r_rd_state, w_rd_state_nxt;

   logic              r_aw_full, r_w_full;
   logic [ADDR_W-1:0] r_awaddr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic [1:0]        r_bresp, r_rresp;
   logic [31:0]       r_rdata;
   logic              r_wr_stb;
   logic [IDX_W-1:0]  r_wr_idx;

   logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_bank_we;
   logic [ADDR_W-1:0] w_awaddr_eff;
   logic [31:0]       w_wdata_eff, w_bank_rdata;
   logic [3:0]        w_wstrb_eff;
   logic              w_aw_in_range, w_ar_in_range;
   logic [IDX_W-1:0]  w_aw_idx, w_ar_idx;
   logic              w_unused;

   assign S_AXI_AWREADY = ~ARESET & ~r_aw_full & (r_wr_state == WR_IDLE);
   assign S_AXI_WREADY  = ~ARESET & ~r_w_full  & (r_wr_state == WR_IDLE);
   assign S_AXI_BVALID  = (r_wr_state == WR_RESP);
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = ~ARESET & (r_rd_state == RD_IDLE);
   assign S_AXI_RVALID  = (r_rd_state == RD_RESP);
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign wr_stb_o      = r_wr_stb;
   assign wr_idx_o      = r_wr_idx;

   assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
   assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   // the half that arrives on the completing edge is used directly, so commit needs no extra cycle
   assign w_awaddr_eff = r_aw_full ? r_awaddr : S_AXI_AWADDR;
   assign w_wdata_eff  = r_w_full  ? r_wdata  : S_AXI_WDATA;
   assign w_wstrb_eff  = r_w_full  ? r_wstrb  : S_AXI_WSTRB;
   assign w_commit     = (r_wr_state == WR_IDLE) & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);

   assign w_aw_in_range = (w_awaddr_eff[ADDR_W-1:2] < LP_NUM_REGS);
   assign w_aw_idx      = w_awaddr_eff[2 +: IDX_W];
   assign w_ar_in_range = (S_AXI_ARADDR[ADDR_W-1:2] < LP_NUM_REGS);
   assign w_ar_idx      = S_AXI_ARADDR[2 +: IDX_W];
   assign w_bank_we     = w_commit & w_aw_in_range;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_awaddr_eff[1:0], S_AXI_ARADDR[1:0]};

   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_rd_state_nxt = r_rd_state;
      case (r_wr_state)
         WR_IDLE: if (w_commit)     w_wr_state_nxt = WR_RESP;
         WR_RESP: if (S_AXI_BREADY) w_wr_state_nxt = WR_IDLE;
         default:                   w_wr_state_nxt = WR_IDLE;
      endcase
      case (r_rd_state)
         RD_IDLE: if (w_ar_hs)      w_rd_state_nxt = RD_RESP;
         RD_RESP: if (S_AXI_RREADY) w_rd_state_nxt = RD_IDLE;
         default:                   w_rd_state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_state <= WR_IDLE;
         r_rd_state <= RD_IDLE;
         r_aw_full  <= 1'b0;
         r_w_full   <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bresp    <= RESP_OKAY;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= '0;
         r_wr_stb   <= 1'b0;
         r_wr_idx   <= '0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_rd_state <= w_rd_state_nxt;
         r_wr_stb   <= w_bank_we;
         if (w_bank_we) r_wr_idx <= w_aw_idx;
         if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bresp   <= w_aw_in_range ? RESP_OKAY : LP_OOR_RESP;
         end else begin
            if (w_aw_hs) begin
               r_aw_full <= 1'b1;
               r_awaddr  <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
               r_w_full <= 1'b1;
               r_wdata  <= S_AXI_WDATA;
               r_wstrb  <= S_AXI_WSTRB;
            end
         end
         if (w_ar_hs) begin
            r_rdata <= w_ar_in_range ? w_bank_rdata : 32'h0;
            r_rresp <= w_ar_in_range ? RESP_OKAY : LP_OOR_RESP;
         end
      end
   end

   axil_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_we    (w_bank_we),
      .i_widx  (w_aw_idx),
      .i_wdata (w_wdata_eff),
      .i_wstrb (w_wstrb_eff),
      .i_ridx  (w_ar_idx),
      .o_rdata (w_bank_rdata),
      .o_regs  (regs_o)
   );

endmodule
